end_screen_controller: RTL and testbench
========================================

Name: end_screen_controller

Overview:
- Sequences the game-over display path: detects a win/lose event and holds the board visible for a reveal delay.
- Switches the display mux to the end-screen renderer, only on a frame boundary to avoid tearing, and drives a blink enable for the message.
- Debounces the reset key and issues a one-cycle game_restart pulse to the game logic.
- Sits between game state logic, VGA timing (frame_start) and the board/end-screen colour mux.

Parameters:
- REVEAL_FRAMES, 120, frames the board stays visible after game end before the end screen appears (0 = switch on the next frame_start).
- BLINK_FRAMES, 30, frames per blink_on half-period on the end screen (0 = no blink, blink_on held 1).
- DEBOUNCE_CYCLES, 250000, clk cycles the synchronized key must be stable before a level change is accepted (>= 1).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- frame_start, input, 1, one-cycle pulse at the start of each frame, from VGA timing.
- game_won, input, 1, level from game logic: all safe cells revealed.
- game_lost, input, 1, level from game logic: mine revealed.
- key_reset_n, input, 1, raw asynchronous push button, active-low.
- show_end, output, 1, 1 = mux selects the end-screen renderer colour.
- win_latched, output, 1, win/lose flag frozen at game end; feeds renderer win input.
- blink_on, output, 1, message visibility gate for the renderer.
- game_restart, output, 1, one-cycle pulse that clears the game/board state.
- state_out, output, 2, current FSM state for debug: PLAY=0, REVEAL=1, END=2, RESTART=3.

Behaviour:
- Reset (rst=0, async): state=PLAY; show_end=0, win_latched=0, blink_on=1, game_restart=0; all counters 0.
  - Synchronizer FFs reset to 1 (released); debounced level resets to 1.
- Key path: 2-FF synchronizer on key_reset_n.
  - Debounce counter increments while the synchronized value differs from the debounced level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the new value.
  - press = one-cycle pulse on a debounced 1->0 transition.
  - Latency from raw edge to press: 2 + DEBOUNCE_CYCLES cycles.
- All outputs are registered; state_out equals the state register.
- PLAY:
  - If press → RESTART. Press has priority over a same-cycle game_won/game_lost.
  - Else if game_won|game_lost → REVEAL; win_latched<=game_won (win wins if both high); frame counter<=0.
  - show_end=0.
- REVEAL:
  - show_end=0. The counter increments on each frame_start.
  - On the frame_start where counter==REVEAL_FRAMES-1, or on any frame_start if REVEAL_FRAMES=0 → END.
  - Entering END sets show_end<=1 in the same clock, so the mux changes only at a frame boundary.
  - On entering END: blink_on<=1, blink counter<=0.
  - Press → RESTART, with priority over the frame transition.
  - Changes to game_won/game_lost are ignored.
- END:
  - show_end=1.
  - If BLINK_FRAMES>0: the blink counter counts frame_start. At count BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
  - Press → RESTART.
- RESTART:
  - game_restart=1 for exactly the entry cycle, then 0.
  - Same clock: show_end<=0, win_latched<=0, blink_on<=1; counters cleared.
  - Remains in RESTART until the debounced level is 1 (key released), then → PLAY.
  - A held key therefore produces exactly one game_restart.
  - game_won/game_lost are ignored, since game logic clears them from game_restart.
- frame_start coinciding with a state transition: the transition is evaluated first; counting starts from the new state's next frame_start.
- Counter widths are sized by $clog2 of the parameter (minimum 1 bit). There is no overflow: counters wrap only at the terminal counts defined above.

Test Plan:
(bench overrides REVEAL_FRAMES=3, BLINK_FRAMES=2, DEBOUNCE_CYCLES=4; frame_start every 20 clk)
- Reset: drive rst=0 mid-END, then release → show_end=0, win_latched=0, blink_on=1, state_out=0 immediately and asynchronously.
- Lose path: game_lost=1 in PLAY → state_out=1, win_latched=0.
  - show_end rises in the same clock as the 3rd subsequent frame_start.
  - blink_on then toggles every 2nd frame_start: 1,1,0,0,1…
- Win and lose same cycle: game_won=game_lost=1 → win_latched=1; show_end=1 after 3 frames.
- Debounce: 3-cycle low glitches on key_reset_n in END → no game_restart.
  - A steady low produces game_restart exactly 6 cycles after the edge, width 1 cycle; state_out=3.
- Held key: keep key low 200 cycles after restart → single game_restart pulse, state stays 3.
  - After release + 6 cycles → state_out=0.
- Press during REVEAL coincident with the 3rd frame_start → RESTART taken, show_end never asserts.

Source files
------------

// File: rtl/end_screen_controller.sv
// rtl/end_screen_controller.sv - game-over display sequencer: reveal delay, frame-aligned end-screen switch, blink, debounced restart
module end_screen_controller #(
  parameter int REVEAL_FRAMES   = 120,
  parameter int BLINK_FRAMES    = 30,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       game_won,
  input  logic       game_lost,
  input  logic       key_reset_n,
  output logic       show_end,
  output logic       win_latched,
  output logic       blink_on,
  output logic       game_restart,
  output logic [1:0] state_out
);

  localparam int RW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [RW-1:0] REVEAL_LAST = RW'((REVEAL_FRAMES > 0) ? REVEAL_FRAMES - 1 : 0);
  localparam logic [BW-1:0] BLINK_LAST  = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);
  localparam logic [DW-1:0] DEB_LAST    = DW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_PLAY    = 2'd0,
    ST_REVEAL  = 2'd1,
    ST_END     = 2'd2,
    ST_RESTART = 2'd3
  } state_t;

  state_t          state;
  logic [RW-1:0]   frame_cnt;
  logic [BW-1:0]   blink_cnt;

  logic            key_s1;
  logic            key_s2;
  logic            key_level;
  logic [DW-1:0]   deb_cnt;
  logic            key_accept;
  logic            press;
  logic            key_release;

  // A level change is accepted on the cycle the counter reaches its terminal count,
  // so press/release are visible to the FSM in that same cycle.
  assign key_accept  = (key_s2 != key_level) && (deb_cnt == DEB_LAST);
  assign press       = key_accept && !key_s2;
  assign key_release = key_accept && key_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_s1    <= 1'b1;
      key_s2    <= 1'b1;
      key_level <= 1'b1;
      deb_cnt   <= '0;
    end else begin
      key_s1 <= key_reset_n;
      key_s2 <= key_s1;
      if (key_s2 == key_level) begin
        deb_cnt <= '0;
      end else if (key_accept) begin
        key_level <= key_s2;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_PLAY;
      show_end     <= 1'b0;
      win_latched  <= 1'b0;
      blink_on     <= 1'b1;
      game_restart <= 1'b0;
      frame_cnt    <= '0;
      blink_cnt    <= '0;
    end else begin
      game_restart <= 1'b0;
      // A press outranks any game event or frame transition in the same cycle.
      if (press && state != ST_RESTART) begin
        state        <= ST_RESTART;
        game_restart <= 1'b1;
        show_end     <= 1'b0;
        win_latched  <= 1'b0;
        blink_on     <= 1'b1;
        frame_cnt    <= '0;
        blink_cnt    <= '0;
      end else begin
        case (state)
          ST_PLAY: begin
            if (game_won || game_lost) begin
              state       <= ST_REVEAL;
              win_latched <= game_won;
              frame_cnt   <= '0;
            end
          end
          ST_REVEAL: begin
            if (frame_start) begin
              if (REVEAL_FRAMES == 0 || frame_cnt == REVEAL_LAST) begin
                state     <= ST_END;
                show_end  <= 1'b1;
                blink_on  <= 1'b1;
                blink_cnt <= '0;
                frame_cnt <= '0;
              end else begin
                frame_cnt <= frame_cnt + 1'b1;
              end
            end
          end
          ST_END: begin
            if (frame_start && BLINK_FRAMES > 0) begin
              if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
              end else begin
                blink_cnt <= blink_cnt + 1'b1;
              end
            end
          end
          ST_RESTART: begin
            // Holding the key keeps us here, so one press yields one restart pulse.
            if (key_level || key_release) begin
              state <= ST_PLAY;
            end
          end
          default: state <= ST_PLAY;
        endcase
      end
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_end_screen_controller.sv
// tb/tb_end_screen_controller.sv - self-checking bench for end_screen_controller
module tb_end_screen_controller;

  localparam int R = 3;
  localparam int B = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       game_won = 1'b0;
  logic       game_lost = 1'b0;
  logic       key_reset_n = 1'b1;
  logic       show_end;
  logic       win_latched;
  logic       blink_on;
  logic       game_restart;
  logic [1:0] state_out;

  end_screen_controller #(
    .REVEAL_FRAMES(R),
    .BLINK_FRAMES(B),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .game_won(game_won),
    .game_lost(game_lost),
    .key_reset_n(key_reset_n),
    .show_end(show_end),
    .win_latched(win_latched),
    .blink_on(blink_on),
    .game_restart(game_restart),
    .state_out(state_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase of the game, frames seen in the current phase,
  // and how long the delayed key has disagreed with the accepted level.
  int   m_st;
  int   m_frames;
  int   m_ef;
  int   m_run;
  logic m_win;
  logic m_restart;
  logic m_deb;
  logic m_r1;
  logic m_r2;

  typedef struct {
    int n;
    int f;
    int w;
    int l;
    int k;
    int st;
    int show;
    int win;
    int blink;
    int rs;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_frames = 0; m_ef = 0; m_run = 0;
    m_win = 1'b0; m_restart = 1'b0; m_deb = 1'b1; m_r1 = 1'b1; m_r2 = 1'b1;
  endtask

  task automatic model_step(input logic f, input logic w, input logic l, input logic k);
    logic synced;
    logic press;
    synced = m_r2;
    m_r2 = m_r1;
    m_r1 = k;
    press = 1'b0;
    if (synced != m_deb) begin
      m_run++;
      if (m_run == D) begin
        m_deb = synced;
        m_run = 0;
        press = !synced;
      end
    end else begin
      m_run = 0;
    end
    m_restart = 1'b0;
    if (press && m_st != 3) begin
      m_st = 3; m_restart = 1'b1; m_win = 1'b0;
    end else begin
      case (m_st)
        0: if (w || l) begin m_st = 1; m_win = w; m_frames = 0; end
        1: if (f) begin
             m_frames++;
             if (m_frames >= R) begin m_st = 2; m_ef = 0; end
           end
        2: if (f) m_ef++;
        default: if (m_deb) m_st = 0;
      endcase
    end
  endtask

  function automatic int model_blink();
    if (m_st != 2 || B == 0) return 1;
    return ((m_ef / B) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic step(input logic f, input logic w, input logic l, input logic k);
    frame_start = f; game_won = w; game_lost = l; key_reset_n = k;
    @(posedge clk);
    model_step(f, w, l, k);
    @(negedge clk);
    chk("model_state", int'(state_out), m_st);
    chk("model_show_end", int'(show_end), (m_st == 2) ? 1 : 0);
    chk("model_win_latched", int'(win_latched), int'(m_win));
    chk("model_blink_on", model_blink(), int'(blink_on) == 1 ? model_blink() : int'(blink_on));
    chk("model_blink_val", int'(blink_on), model_blink());
    chk("model_game_restart", int'(game_restart), int'(m_restart));
  endtask

  initial begin
    int first;
    int pulses;
    int hold;
    logic kr;
    logic seen_show;

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_state", int'(state_out), 0);
    chk("reset_show_end", int'(show_end), 0);
    chk("reset_win", int'(win_latched), 0);
    chk("reset_blink", int'(blink_on), 1);
    chk("reset_restart", int'(game_restart), 0);
    rst = 1'b1;

    //               n f w l k  st sh wn bl rs
    tbl.push_back('{2, 0, 0, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{3, 0, 0, 0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 2, 1, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 2, 1, 0, 1, 0});
    tbl.push_back('{2, 0, 0, 0, 1, 2, 1, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 2, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 2, 1, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 2, 1, 0, 1, 0});
    tbl.push_back('{5, 0, 0, 0, 0, 2, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 3, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 3, 0, 0, 1, 0});
    tbl.push_back('{5, 0, 0, 0, 1, 3, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 1, 1, 1, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 1, 0, 1, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 1, 0, 1, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 1, 0, 1, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 2, 1, 1, 1, 0});
    tbl.push_back('{3, 0, 0, 0, 0, 2, 1, 1, 1, 0});
    tbl.push_back('{4, 0, 0, 0, 1, 2, 1, 1, 1, 0});

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++)
        step(tbl[i].f[0], tbl[i].w[0], tbl[i].l[0], tbl[i].k[0]);
      chk($sformatf("vec%0d_state", i), int'(state_out), tbl[i].st);
      chk($sformatf("vec%0d_show_end", i), int'(show_end), tbl[i].show);
      chk($sformatf("vec%0d_win", i), int'(win_latched), tbl[i].win);
      chk($sformatf("vec%0d_blink", i), int'(blink_on), tbl[i].blink);
      chk($sformatf("vec%0d_restart", i), int'(game_restart), tbl[i].rs);
    end

    // Asynchronous reset in the middle of END, away from any clock edge.
    chk("pre_reset_show_end", int'(show_end), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_state", int'(state_out), 0);
    chk("async_reset_show_end", int'(show_end), 0);
    chk("async_reset_win", int'(win_latched), 0);
    chk("async_reset_blink", int'(blink_on), 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();

    // Held key from END: exactly one restart, 6 cycles after the edge.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 60; i++) step((i % 20) == 0, 1'b0, 1'b0, 1'b1);
    chk("held_pre_state", int'(state_out), 2);
    first = 0; pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      step((i % 20) == 0, 1'b0, 1'b0, 1'b0);
      if (game_restart) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    chk("held_restart_latency", first, 6);
    chk("held_restart_pulses", pulses, 1);
    chk("held_state", int'(state_out), 3);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("release_5_state", int'(state_out), 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("release_6_state", int'(state_out), 0);

    // Press accepted on the same edge as the 3rd reveal frame_start.
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    seen_show = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      seen_show |= show_end;
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    seen_show |= show_end;
    chk("coincide_state", int'(state_out), 3);
    chk("coincide_restart", int'(game_restart), 1);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      seen_show |= show_end;
    end
    chk("coincide_show_never", int'(seen_show), 0);
    chk("coincide_back_play", int'(state_out), 0);

    // Randomized traffic against the reference model.
    hold = 0; kr = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        kr = ($urandom_range(0, 2) != 0);
        hold = $urandom_range(1, 9);
      end
      hold--;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 15) == 0, kr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
